// File: rtl/plic_pkg.sv
// Shared PLIC constants and types. Source count, priority width and ID width come from the
// `PLIC_* defines; the fallbacks below apply only when no build-level define is given.
`ifndef PLIC_IRQ_NUM
`define PLIC_IRQ_NUM 12
`endif
`ifndef PLIC_PRIO_WIDTH
`define PLIC_PRIO_WIDTH 3
`endif
`ifndef PLIC_IRQ_WIDTH
`define PLIC_IRQ_WIDTH 4
`endif

package plic_pkg;

  localparam int unsigned SRC_NUM    = `PLIC_IRQ_NUM;
  localparam int unsigned PRIO_WIDTH = `PLIC_PRIO_WIDTH;
  localparam int unsigned ID_WIDTH   = `PLIC_IRQ_WIDTH;

  typedef logic [PRIO_WIDTH-1:0] prio_t;
  typedef logic [ID_WIDTH-1:0]   id_t;

  typedef enum logic [0:0] {
    IDLE,
    RESP
  } claim_state_e;

endpackage

// File: rtl/prio_tree.sv
// Max/argmax selector over per-source priorities. Ties resolve to the lower index, and an
// all-zero input yields priority 0 with ID 0.
module prio_tree
  import plic_pkg::*;
#(
  parameter int unsigned N = SRC_NUM
) (
  input  prio_t [N-1:0] prio_i,
  output prio_t         max_prio_o,
  output id_t           max_id_o
);

  prio_t best_prio;
  id_t   best_id;

  // Ascending scan with strict compare keeps the lowest index on ties.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (prio_i[i] > best_prio) begin
        best_prio = prio_i[i];
        best_id   = id_t'(i);
      end
    end
  end

  assign max_prio_o = best_prio;
  assign max_id_o   = best_id;

endmodule

// File: rtl/plic_claim_ctrl.sv
// Per-target PLIC claim/complete sequencer: masks pending sources, arbitrates, drives the
// target interrupt, and returns gateway clear/complete pulses. All outputs are registered.
module plic_claim_ctrl
  import plic_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic  [SRC_NUM-1:0]  pend_i,
  input  logic  [SRC_NUM-1:0]  en_i,
  input  prio_t [SRC_NUM-1:0]  prio_i,
  input  prio_t                thold_i,
  input  logic                 claim_i,
  output logic                 claim_vld_o,
  output id_t                  claim_id_o,
  input  logic                 cmpl_i,
  input  id_t                  cmpl_id_i,
  output logic  [SRC_NUM-1:0]  gw_clr_o,
  output logic  [SRC_NUM-1:0]  gw_cmpl_o,
  output logic  [SRC_NUM-1:0]  in_srv_o,
  output logic                 irq_o
);

  localparam logic [SRC_NUM-1:0] SrcOne = SRC_NUM'(1);

  claim_state_e       state_q, state_d;
  prio_t              best_prio_q, best_prio_d;
  id_t                best_id_q, best_id_d;
  id_t                claim_id_q, claim_id_d;
  logic               claim_vld_q, claim_vld_d;
  logic [SRC_NUM-1:0] in_srv_q, in_srv_d;
  logic [SRC_NUM-1:0] gw_clr_q, gw_clr_d;
  logic [SRC_NUM-1:0] gw_cmpl_q, gw_cmpl_d;
  logic               irq_q, irq_d;

  logic [SRC_NUM-1:0] elig;
  prio_t [SRC_NUM-1:0] eff_prio;
  logic               claim_hit, above_thold, cmpl_ok;
  id_t                claim_sel;
  logic [SRC_NUM-1:0] set_mask, cmpl_mask;

  always_comb begin
    elig    = pend_i & en_i & ~in_srv_q;
    elig[0] = 1'b0;
    for (int unsigned i = 0; i < SRC_NUM; i++) begin
      eff_prio[i] = elig[i] ? prio_i[i] : '0;
    end
  end

  prio_tree #(
    .N (SRC_NUM)
  ) u_prio_tree (
    .prio_i     (eff_prio),
    .max_prio_o (best_prio_d),
    .max_id_o   (best_id_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (claim_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    claim_hit   = (state_q == IDLE) && claim_i;
    above_thold = best_prio_q > thold_i;
    claim_sel   = above_thold ? best_id_q : '0;
    // Bit 0 is reserved, so an ID of 0 (or an out-of-range ID) never produces a mask bit.
    set_mask    = (SrcOne << claim_sel) & ~SrcOne;
    cmpl_mask   = (SrcOne << cmpl_id_i) & ~SrcOne;
    cmpl_ok     = cmpl_i && |(cmpl_mask & in_srv_q);

    in_srv_d = in_srv_q;
    if (claim_hit) in_srv_d = in_srv_d | set_mask;
    if (cmpl_ok)   in_srv_d = in_srv_d & ~cmpl_mask;

    claim_id_d  = claim_hit ? claim_sel : claim_id_q;
    claim_vld_d = claim_hit;
    gw_clr_d    = claim_hit ? set_mask : '0;
    gw_cmpl_d   = cmpl_ok ? cmpl_mask : '0;
    // Suppressed through RESP and the cycle after, while best_*_q still predates in_srv.
    irq_d       = (state_q == IDLE) && !claim_i && above_thold;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      best_prio_q <= '0;
      best_id_q   <= '0;
      claim_id_q  <= '0;
      claim_vld_q <= 1'b0;
      in_srv_q    <= '0;
      gw_clr_q    <= '0;
      gw_cmpl_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      best_prio_q <= best_prio_d;
      best_id_q   <= best_id_d;
      claim_id_q  <= claim_id_d;
      claim_vld_q <= claim_vld_d;
      in_srv_q    <= in_srv_d;
      gw_clr_q    <= gw_clr_d;
      gw_cmpl_q   <= gw_cmpl_d;
      irq_q       <= irq_d;
    end
  end

  assign claim_vld_o = claim_vld_q;
  assign claim_id_o  = claim_id_q;
  assign gw_clr_o    = gw_clr_q;
  assign gw_cmpl_o   = gw_cmpl_q;
  assign in_srv_o    = in_srv_q;
  assign irq_o       = irq_q;

endmodule

// File: doc/plic_claim_ctrl.md
Name: plic_claim_ctrl

Overview:
Per-target claim/complete sequencer for the PLIC.
- Masks source pending bits with enables and with its own in-service bits.
- Selects the highest-priority eligible source through the priority tree and registers the result.
- Compares the result against the target threshold and drives the target interrupt line.
- Sequences the claim read and the complete write, returning gateway clear/complete pulses.
- One instance per target context, between the gateways/register file and the hart interrupt input.

Parameters:
SRC_NUM, `PLIC_IRQ_NUM, number of interrupt sources including reserved source 0
PRIO_WIDTH, `PLIC_PRIO_WIDTH, priority field width
ID_WIDTH, `PLIC_IRQ_WIDTH, source ID width, equal to $clog2(SRC_NUM)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
pend_i  in  SRC_NUM  gateway pending bits; bit 0 is ignored
en_i  in  SRC_NUM  per-source enable for this target
prio_i  in  SRC_NUM x PRIO_WIDTH  per-source priority
thold_i  in  PRIO_WIDTH  target threshold
claim_i  in  1  single-cycle claim-register read strobe
claim_vld_o  out  1  claim response valid, one-cycle pulse
claim_id_o  out  ID_WIDTH  claimed ID; 0 means no interrupt
cmpl_i  in  1  single-cycle complete-register write strobe
cmpl_id_i  in  ID_WIDTH  ID being completed
gw_clr_o  out  SRC_NUM  one-hot pulse that clears the gateway pending bit
gw_cmpl_o  out  SRC_NUM  one-hot pulse that re-arms the gateway
in_srv_o  out  SRC_NUM  in-service bits, for debug/status
irq_o  out  1  target interrupt request, registered

Behaviour:
- Reset (async, active-high):
  - state = IDLE; best_prio_q = 0; best_id_q = 0; in_srv = 0.
  - All outputs 0.
- Eligibility: elig[i] = pend_i[i] & en_i[i] & ~in_srv[i] & (i != 0).
- Arbitration input: effective priority is prio_i[i] where elig[i], else 0.
- Arbitration: combinational priority tree.
  - Highest priority wins.
  - On equal priority the lower ID wins.
- Result registration: best_prio_q/best_id_q are captured every clock, giving 1-cycle latency from inputs.
- Interrupt line: irq_o is registered.
  - Next-state value is 1 when state == IDLE && best_prio_q > thold_i (strict greater-than).
  - Priority 0 never interrupts.
  - thold_i = all-ones masks everything.
- FSM states:
  - IDLE → RESP on claim_i.
  - RESP → IDLE unconditionally after 1 cycle.
- Claim, with claim_i sampled in IDLE at cycle N:
  - Latch claim_id_q = (best_prio_q > thold_i) ? best_id_q : 0.
  - If the latched ID is non-zero, set in_srv[id].
  - Cycle N+1 (RESP): claim_vld_o = 1, claim_id_o = claim_id_q.
  - Cycle N+1: gw_clr_o[id] = 1 for one cycle; no pulse if the ID is 0.
  - Cycle N+1: irq_o forced 0, because best_*_q is stale during RESP.
  - Back in IDLE, irq_o reflects arbitration with the updated in_srv.
- claim_i during RESP: ignored, with no response. The bus side must not issue claims 1 cycle apart.
- claim_id_o holds its last value when claim_vld_o = 0.
- Complete: accepted in any state.
  - If cmpl_id_i is in 1..SRC_NUM-1 and in_srv[cmpl_id_i] = 1: clear that bit at the next edge and pulse gw_cmpl_o[cmpl_id_i] in the following cycle.
  - Otherwise: silently ignored, with no pulse and no state change.
- Claim and complete in the same cycle: both are processed.
  - The IDs necessarily differ, because the claimed source is already masked by in_srv.
  - Set and clear apply to separate bits.
- A claim with no eligible source returns ID 0 and changes nothing.
- Pending deasserting between arbitration and claim: the latched ID is still returned and marked in-service; software completes it normally.
- Reset asserted mid-RESP: immediately returns to the reset state, with no pulses emitted.
- No combinational path from any input to any output.

Decomposition:
- Shared package plic_pkg holds:
  - SRC_NUM/PRIO_WIDTH/ID_WIDTH constants mapped from the `PLIC_* defines.
  - Enum claim_state_e {IDLE, RESP}.
  - prio_t and id_t typedefs.
- Sub-module: the existing prio_tree, instantiated once for the max/argmax selection.
- Everything else (masking, FSM, in_srv register, pulse generation) is local.

Test Plan:
- Reset release, all inputs 0: irq_o = 0, claim_vld_o = 0, and in_srv_o/gw_clr_o/gw_cmpl_o are 0 every cycle.
- pend = {3,5}, en all 1, prio[3]=2, prio[5]=6, thold=1:
  - irq_o = 1 two cycles after pend is applied.
  - A claim returns ID 5 with gw_clr_o = 1<<5.
  - irq_o = 0 during RESP, then 1 again (ID 3 remains).
  - A second claim returns ID 3.
- prio[4] = prio[9] = 3, both pending/enabled:
  - A claim returns 4 (tie → lower ID).
  - A complete with ID 4 then pulses gw_cmpl_o = 1<<4 and clears in_srv_o[4].
- thold = 6 with a max pending priority of 6: irq_o stays 0, and a claim returns ID 0 with no gw_clr_o pulse.
- Complete with ID 7 (not in-service), with ID 0, and with ID ≥ SRC_NUM: no gw_cmpl_o pulse, and in_srv_o is unchanged.
- Claim strobes in consecutive cycles:
  - Only the first produces claim_vld_o.
  - A same-cycle claim of source 2 with complete of source 6 sets bit 2 and clears bit 6.
  - Reset asserted during RESP clears all state asynchronously.
